// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: states, opcodes, bus select codes,
// C-bus write-enable bit positions, ALU ops and the registered output bundle.
package cu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH1,
        ST_FETCH2,
        ST_FETCH3,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_EXEC3,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MOV   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] SEL_DR = 4'd0;
    localparam logic [3:0] SEL_R1 = 4'd1;
    localparam logic [3:0] SEL_R2 = 4'd2;
    localparam logic [3:0] SEL_R3 = 4'd3;
    localparam logic [3:0] SEL_RA = 4'd4;
    localparam logic [3:0] SEL_RB = 4'd5;
    localparam logic [3:0] SEL_RC = 4'd6;
    localparam logic [3:0] SEL_AC = 4'd7;
    localparam logic [3:0] SEL_PC = 4'd8;

    localparam int unsigned CB_PC = 9;
    localparam int unsigned CB_RA = 8;
    localparam int unsigned CB_RB = 7;
    localparam int unsigned CB_RC = 6;
    localparam int unsigned CB_R1 = 5;
    localparam int unsigned CB_R2 = 4;
    localparam int unsigned CB_R3 = 3;
    localparam int unsigned CB_DR = 2;
    localparam int unsigned CB_AR = 1;
    localparam int unsigned CB_AC = 0;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef struct packed {
        logic [9:0] ctrl;
        logic [3:0] sel;
        logic       pc_inc;
        logic       ac_inc;
        logic       ra_inc;
        logic       rb_inc;
        logic       rc_inc;
        logic       rd;
        logic       wr;
        logic       ldir;
        logic [1:0] alu;
        logic       halted;
    } cu_out_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction field decode: opcode, source, destination
// write-enable one-hot, increment strobe selection and undefined-opcode flag.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [3:0]  opcode_o,
    output logic [3:0]  src_o,
    output logic [9:0]  dst_we_o,
    output logic [4:0]  inc_o,
    output logic        undef_o
);

    logic unused_bits;
    assign unused_bits = ^instr_i[11:8];

    always_comb begin
        opcode_o = instr_i[15:12];
        src_o    = instr_i[3:0];
        dst_we_o = '0;
        if (instr_i[7:4] <= 4'd9) begin
            dst_we_o = 10'd1 << instr_i[7:4];
        end
        // inc_o order: {PC, AC, RA, RB, RC}
        inc_o = '0;
        case (instr_i[3:0])
            SEL_PC:  inc_o = 5'b10000;
            SEL_AC:  inc_o = 5'b01000;
            SEL_RA:  inc_o = 5'b00100;
            SEL_RB:  inc_o = 5'b00010;
            SEL_RC:  inc_o = 5'b00001;
            default: inc_o = '0;
        endcase
        undef_o = (opcode_o >= 4'h9) && (opcode_o <= 4'hE);
    end

endmodule

// File: rtl/control_unit.sv
// Microsequenced control unit: fetch/decode/execute FSM with registered outputs.
// Optional CU_ILLEGAL_TRAP_EN: undefined opcodes set sticky illegal and halt.
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        z_flag,
    output logic [9:0]  C_bus_ctrl_sig,
    output logic [3:0]  select,
    output logic        PC_INC,
    output logic        AC_INC,
    output logic        RA_INC,
    output logic        RB_INC,
    output logic        RC_INC,
    output logic        read,
    output logic        write,
    output logic        LDIR,
    output logic [1:0]  alu_op,
    output logic        halted,
    output logic        illegal
);

    state_t     state_q, state_d;
    cu_out_t    out_q, out_d;
    logic [3:0] opcode, src;
    logic [9:0] dst_we;
    logic [4:0] inc;
    logic       undef;

    cu_decoder u_dec (
        .instr_i  (instr),
        .opcode_o (opcode),
        .src_o    (src),
        .dst_we_o (dst_we),
        .inc_o    (inc),
        .undef_o  (undef)
    );

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // Outputs are computed for the state being entered so they are registered
    // alongside it; instr is stable from DECODE through the last EXEC state.
    always_comb begin
        state_d = state_q;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH1;
            ST_FETCH1: state_d = ST_FETCH2;
            ST_FETCH2: state_d = ST_FETCH3;
            ST_FETCH3: state_d = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (undef) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
`else
                    state_d = ST_FETCH1;
`endif
                end else if (opcode == OP_NOP) begin
                    state_d = ST_FETCH1;
                end else begin
                    state_d = ST_EXEC1;
                end
            end
            ST_EXEC1:  state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? ST_EXEC2 : ST_FETCH1;
            ST_EXEC2:  state_d = ST_EXEC3;
            ST_EXEC3:  state_d = ST_FETCH1;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase

        out_d = '0;
        case (state_d)
            ST_FETCH1: begin
                out_d.sel         = SEL_PC;
                out_d.ctrl[CB_AR] = 1'b1;
            end
            ST_FETCH2: begin
                out_d.rd     = 1'b1;
                out_d.pc_inc = 1'b1;
            end
            ST_FETCH3: out_d.ldir = 1'b1;
            ST_EXEC1: begin
                case (opcode)
                    OP_MOV: begin
                        out_d.sel  = src;
                        out_d.ctrl = dst_we;
                    end
                    OP_LOAD, OP_STORE: begin
                        out_d.sel         = src;
                        out_d.ctrl[CB_AR] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        out_d.sel         = src;
                        out_d.alu         = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                        out_d.ctrl[CB_AC] = 1'b1;
                    end
                    OP_INC: {out_d.pc_inc, out_d.ac_inc, out_d.ra_inc,
                             out_d.rb_inc, out_d.rc_inc} = inc;
                    OP_JMP, OP_JZ: begin
                        if (opcode == OP_JMP || z_flag) begin
                            out_d.sel         = src;
                            out_d.ctrl[CB_PC] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                if (opcode == OP_LOAD) begin
                    out_d.rd = 1'b1;
                end else begin
                    out_d.sel         = SEL_AC;
                    out_d.ctrl[CB_DR] = 1'b1;
                end
            end
            ST_EXEC3: begin
                if (opcode == OP_LOAD) begin
                    out_d.sel         = SEL_DR;
                    out_d.alu         = ALU_PASS;
                    out_d.ctrl[CB_AC] = 1'b1;
                end else begin
                    out_d.wr = 1'b1;
                end
            end
            ST_HALT:   out_d.halted = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign C_bus_ctrl_sig = out_q.ctrl;
    assign select         = out_q.sel;
    assign PC_INC         = out_q.pc_inc;
    assign AC_INC         = out_q.ac_inc;
    assign RA_INC         = out_q.ra_inc;
    assign RB_INC         = out_q.rb_inc;
    assign RC_INC         = out_q.rc_inc;
    assign read           = out_q.rd;
    assign write          = out_q.wr;
    assign LDIR           = out_q.ldir;
    assign alu_op         = out_q.alu;
    assign halted         = out_q.halted;
`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal        = illegal_q;
`else
    assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected cycle traces
// built from the instruction semantics, random and directed instruction streams.
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] instr;
    logic        z_flag;
    logic [9:0]  C_bus_ctrl_sig;
    logic [3:0]  select;
    logic        PC_INC, AC_INC, RA_INC, RB_INC, RC_INC;
    logic        read, write, LDIR;
    logic [1:0]  alu_op;
    logic        halted, illegal;

    int unsigned total = 0;
    int unsigned bad   = 0;

    control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .instr          (instr),
        .z_flag         (z_flag),
        .C_bus_ctrl_sig (C_bus_ctrl_sig),
        .select         (select),
        .PC_INC         (PC_INC),
        .AC_INC         (AC_INC),
        .RA_INC         (RA_INC),
        .RB_INC         (RB_INC),
        .RC_INC         (RC_INC),
        .read           (read),
        .write          (write),
        .LDIR           (LDIR),
        .alu_op         (alu_op),
        .halted         (halted),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [25:0] obs;
    assign obs = {C_bus_ctrl_sig, select, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC,
                  read, write, LDIR, alu_op, halted, illegal};

    // inc = {PC, AC, RA, RB, RC}
    function automatic logic [25:0] mk(input logic [9:0] c, input logic [3:0] s,
                                       input logic [4:0] inc, input logic rd,
                                       input logic wr, input logic ld,
                                       input logic [1:0] alu, input logic h,
                                       input logic il);
        return {c, s, inc, rd, wr, ld, alu, h, il};
    endfunction

    function automatic logic [9:0] bit10(input int unsigned idx);
        logic [9:0] v;
        v = '0;
        if (idx <= 9) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [25:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        total++;
        assert (($countones(C_bus_ctrl_sig) <= 1) && !(read && write)) else begin
            bad++;
            $error("FAIL %s_exclusive observed ctrl=%b rd=%b wr=%b expected onehot0 and not rd&wr",
                   tag, C_bus_ctrl_sig, read, write);
        end
    endtask

    logic [25:0] expq[$];

    // Precondition: FETCH1 of this instruction has just been observed.
    task automatic run_instr(input logic [15:0] ins, input logic z, input string tag);
        logic [3:0] opc, src, dst;
        logic       halts;
        logic       il;
        opc   = ins[15:12];
        src   = ins[3:0];
        dst   = ins[7:4];
        halts = 1'b0;
        il    = 1'b0;
        expq.delete();
        expq.push_back(mk('0, 4'd0, 5'b10000, 1, 0, 0, 2'd0, 0, 0));  // RAM->DR, PC++
        expq.push_back(mk('0, 4'd0, 5'b00000, 0, 0, 1, 2'd0, 0, 0));  // IR load
        expq.push_back('0);                                            // decode
        case (opc)
            4'h0: ;
            4'h1: expq.push_back(mk(bit10(dst), src, '0, 0, 0, 0, 2'd0, 0, 0));
            4'h2: begin
                expq.push_back(mk(bit10(1), src, '0, 0, 0, 0, 2'd0, 0, 0));
                expq.push_back(mk('0, 4'd0, '0, 1, 0, 0, 2'd0, 0, 0));
                expq.push_back(mk(bit10(0), 4'd0, '0, 0, 0, 0, 2'd0, 0, 0));
            end
            4'h3: begin
                expq.push_back(mk(bit10(1), src, '0, 0, 0, 0, 2'd0, 0, 0));
                expq.push_back(mk(bit10(2), 4'd7, '0, 0, 0, 0, 2'd0, 0, 0));
                expq.push_back(mk('0, 4'd0, '0, 0, 1, 0, 2'd0, 0, 0));
            end
            4'h4: expq.push_back(mk(bit10(0), src, '0, 0, 0, 0, 2'd1, 0, 0));
            4'h5: expq.push_back(mk(bit10(0), src, '0, 0, 0, 0, 2'd2, 0, 0));
            4'h6: begin
                logic [4:0] v;
                v = (src == 8) ? 5'b10000 : (src == 7) ? 5'b01000 :
                    (src == 4) ? 5'b00100 : (src == 5) ? 5'b00010 :
                    (src == 6) ? 5'b00001 : 5'b00000;
                expq.push_back(mk('0, 4'd0, v, 0, 0, 0, 2'd0, 0, 0));
            end
            4'h7: expq.push_back(mk(bit10(9), src, '0, 0, 0, 0, 2'd0, 0, 0));
            4'h8: expq.push_back(z ? mk(bit10(9), src, '0, 0, 0, 0, 2'd0, 0, 0) : '0);
            4'hF: halts = 1'b1;
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                halts = 1'b1;
                il    = 1'b1;
`endif
            end
        endcase
        if (halts) begin
            for (int i = 0; i < 4; i++) expq.push_back(mk('0, 4'd0, '0, 0, 0, 0, 2'd0, 1, il));
        end else begin
            expq.push_back(mk(bit10(1), 4'd8, '0, 0, 0, 0, 2'd0, 0, 0));
        end
        instr  = ins;
        z_flag = z;
        for (int i = 0; i < expq.size(); i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_%h_c%0d", tag, ins, i), expq[i]);
        end
    endtask

    task automatic reset_restart(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_rst_async"}, '0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check({tag, "_idle_hold"}, '0);
        end
        run = 1'b1;
        @(posedge clk); #1;
        check({tag, "_fetch1"}, mk(bit10(1), 4'd8, '0, 0, 0, 0, 2'd0, 0, 0));
        run = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        run    = 1'b0;
        instr  = '0;
        z_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_hold", '0);
        end
        run = 1'b1;
        @(posedge clk); #1;
        check("first_fetch1", mk(bit10(1), 4'd8, '0, 0, 0, 0, 2'd0, 0, 0));
        run = 1'b0;

        run_instr(16'h0000, 1'b0, "nop");
        run_instr(16'h2004, 1'b0, "load");
        run_instr(16'h3005, 1'b0, "store");
        run_instr(16'h8001, 1'b1, "jz_taken");
        run_instr(16'h8001, 1'b0, "jz_not");
        run_instr(16'h1390, 1'b0, "mov_dst9");
        run_instr(16'h11C2, 1'b0, "mov_dst12");
        run_instr(16'h6008, 1'b0, "inc_pc");
        run_instr(16'h6003, 1'b0, "inc_none");

        for (int n = 0; n < 40; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            ri[15:12] = 4'($urandom_range(0, 8));
            run_instr(ri, 1'($urandom_range(0, 1)), "rand");
        end

        // reset in the middle of LOAD, while EXEC2 is driving read
        instr = 16'h2004;
        z_flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 4) check("load_exec2_pre_rst", mk('0, 4'd0, '0, 1, 0, 0, 2'd0, 0, 0));
        end
        reset_restart("midload");

        run_instr(16'hA000, 1'b0, "undef");
`ifdef CU_ILLEGAL_TRAP_EN
        reset_restart("after_trap");
`endif
        run_instr(16'hF000, 1'b0, "halt");
        reset_restart("after_halt");
        run_instr(16'h4007, 1'b0, "add_post");
        run_instr(16'h5002, 1'b0, "sub_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
